// File: rtl/rfaludm_pkg.sv
// Shared constants for the RFALUDM controller: state codes, opcodes, funct codes, ALU codes.
package rfaludm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MADDR  = 4'd2;
    localparam state_t S_MRD    = 4'd3;
    localparam state_t S_MWB    = 4'd4;
    localparam state_t S_MWR    = 4'd5;
    localparam state_t S_REXEC  = 4'd6;
    localparam state_t S_RWB    = 4'd7;
    localparam state_t S_BR     = 4'd8;
    localparam state_t S_IEXEC  = 4'd9;
    localparam state_t S_IWB    = 4'd10;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] ALU_AND = 5'h00;
    localparam logic [4:0] ALU_OR  = 5'h01;
    localparam logic [4:0] ALU_ADD = 5'h02;
    localparam logic [4:0] ALU_SUB = 5'h06;
    localparam logic [4:0] ALU_SLT = 5'h07;

endpackage

// File: rtl/rfaludm_ctrl_if.sv
// Instruction handshake and datapath control bundle for rfaludm_ctrl.
// Perf counter signals exist only when RFALUDM_CTRL_PERF_EN is defined.
interface rfaludm_ctrl_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 5
);
    logic               InstrValid;
    logic [INSTR_W-1:0] Instr;
    logic               Zero;
    logic               InstrReady;
    logic [4:0]         Read1;
    logic [4:0]         Read2;
    logic [4:0]         ins_15_11;
    logic [15:0]        SEin;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrc;
    logic               MemtoReg;
    logic               MemWrite;
    logic               MemRead;
    logic [ALUOP_W-1:0] ALUOp;
    logic               BranchTaken;
    logic               Done;
    logic               Illegal;
`ifdef RFALUDM_CTRL_PERF_EN
    logic [31:0]        InstrCount;
    logic [15:0]        IllegalCount;
`endif

    modport slave (
        input  InstrValid, Instr, Zero,
        output InstrReady, Read1, Read2, ins_15_11, SEin,
               RegDst, RegWrite, ALUSrc, MemtoReg, MemWrite, MemRead,
               ALUOp, BranchTaken, Done, Illegal
`ifdef RFALUDM_CTRL_PERF_EN
             , InstrCount, IllegalCount
`endif
    );

    modport master (
        output InstrValid, Instr, Zero,
        input  InstrReady, Read1, Read2, ins_15_11, SEin,
               RegDst, RegWrite, ALUSrc, MemtoReg, MemWrite, MemRead,
               ALUOp, BranchTaken, Done, Illegal
`ifdef RFALUDM_CTRL_PERF_EN
             , InstrCount, IllegalCount
`endif
    );
endinterface

// File: rtl/rfaludm_alu_dec.sv
// R-type funct -> ALU operation decoder; flags functs the ALU does not support.
module rfaludm_alu_dec
    import rfaludm_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic       illegal
);
    always_comb begin
        alu_op  = ALU_AND;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/rfaludm_ctrl.sv
// Multi-cycle control FSM for the RFALUDM datapath: latches one instruction per
// handshake and sequences Moore strobes. RFALUDM_CTRL_PERF_EN adds Done/Illegal counters.
module rfaludm_ctrl
    import rfaludm_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 5
) (
    input  logic            Clock,
    input  logic            Reset,
    rfaludm_ctrl_if.slave   bus
);
    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [5:0]         opcode;
    logic [4:0]         fn_op;
    logic               fn_ill;
    logic               op_ill;
    logic               accept;

    logic               reg_dst, reg_write, alu_src, mem_to_reg, mem_write, mem_read;
    logic               branch_taken, done, illegal;
    logic [ALUOP_W-1:0] alu_op;

    assign opcode = ir_q[31:26];
    assign accept = bus.InstrValid && (state_q == S_FETCH);
    assign op_ill = !(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI});

    rfaludm_alu_dec u_alu_dec (
        .funct   (ir_q[5:0]),
        .alu_op  (fn_op),
        .illegal (fn_ill)
    );

    always_comb begin
        ir_d    = accept ? bus.Instr : ir_q;
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (accept) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:          state_d = S_REXEC;
                    OP_LW, OP_SW:  state_d = S_MADDR;
                    OP_BEQ:        state_d = S_BR;
                    OP_ADDI:       state_d = S_IEXEC;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MADDR:  state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:    state_d = S_MWB;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Strobes depend only on state (plus Zero for the branch flag), so a reset
    // forces them low immediately with no sequencing glitch.
    always_comb begin
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        mem_read     = 1'b0;
        branch_taken = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        alu_op       = '0;
        case (state_q)
            S_DECODE: illegal = op_ill;
            S_MADDR, S_IEXEC: begin
                alu_src = 1'b1;
                alu_op  = ALUOP_W'(ALU_ADD);
            end
            S_MRD: begin
                alu_src  = 1'b1;
                alu_op   = ALUOP_W'(ALU_ADD);
                mem_read = 1'b1;
            end
            S_MWB: begin
                alu_src    = 1'b1;
                alu_op     = ALUOP_W'(ALU_ADD);
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            S_MWR: begin
                alu_src   = 1'b1;
                alu_op    = ALUOP_W'(ALU_ADD);
                mem_write = 1'b1;
                done      = 1'b1;
            end
            S_REXEC: begin
                alu_op  = ALUOP_W'(fn_op);
                illegal = fn_ill;
            end
            S_RWB: begin
                alu_op    = ALUOP_W'(fn_op);
                reg_dst   = 1'b1;
                reg_write = !fn_ill;
                done      = 1'b1;
            end
            S_BR: begin
                alu_op       = ALUOP_W'(ALU_SUB);
                branch_taken = bus.Zero;
                done         = 1'b1;
            end
            S_IWB: begin
                alu_src   = 1'b1;
                alu_op    = ALUOP_W'(ALU_ADD);
                reg_write = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef RFALUDM_CTRL_PERF_EN
    logic [31:0] icnt_q, icnt_d;
    logic [15:0] ill_q, ill_d;

    always_comb begin
        icnt_d = icnt_q + {31'd0, done};
        ill_d  = (illegal && (ill_q != 16'hFFFF)) ? ill_q + 16'd1 : ill_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            icnt_q <= '0;
            ill_q  <= '0;
        end else begin
            icnt_q <= icnt_d;
            ill_q  <= ill_d;
        end
    end

    assign bus.InstrCount   = icnt_q;
    assign bus.IllegalCount = ill_q;
`endif

    assign bus.InstrReady  = (state_q == S_FETCH);
    assign bus.Read1       = ir_q[25:21];
    assign bus.Read2       = ir_q[20:16];
    assign bus.ins_15_11   = ir_q[15:11];
    assign bus.SEin        = ir_q[15:0];
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrc      = alu_src;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.MemWrite    = mem_write;
    assign bus.MemRead     = mem_read;
    assign bus.ALUOp       = alu_op;
    assign bus.BranchTaken = branch_taken;
    assign bus.Done        = done;
    assign bus.Illegal     = illegal;

endmodule
